// File: rtl/gmii_pll_ctrl.sv
// Sequences the GMII reference PLL through reset, lock settling and retries,
// and reprograms its output dividers when the link speed changes.
module gmii_pll_ctrl #(
    parameter int unsigned RST_CYC      = 16,
    parameter int unsigned SETTLE_CYC   = 1024,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned MAX_RETRY    = 4,
    parameter logic [6:0]  ODSEL0_1000  = 7'd8,
    parameter logic [6:0]  ODSEL0_100   = 7'd40,
    parameter logic [6:0]  ODSEL0_10    = 7'd100,
    parameter logic [6:0]  ODSEL1_1000  = 7'd40,
    parameter logic [6:0]  ODSEL1_100   = 7'd40,
    parameter logic [6:0]  ODSEL1_10    = 7'd40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed_sel,
    input  logic       req,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [6:0] odsel0,
    output logic [6:0] odsel1,
    output logic [1:0] speed_cur,
    output logic       ready,
    output logic       busy,
    output logic       err,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned RW = $clog2(RST_CYC + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned YW = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_LOCKED    = 2'd2,
        S_ERROR     = 2'd3
    } state_t;

    state_t        state;
    logic          lock_meta;
    logic          lock_s;
    logic [RW-1:0] rst_cnt;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [YW-1:0] retry_cnt;
    logic          pend_vld;
    logic [1:0]    pend_speed;

    logic          req_vld_c;
    logic [1:0]    eff_speed_c;
    logic          chg_c;
    logic [6:0]    odsel0_nxt_c;
    logic [6:0]    odsel1_nxt_c;

    function automatic logic [6:0] odsel0_of(input logic [1:0] s);
        case (s)
            2'b10:   return ODSEL0_1000;
            2'b01:   return ODSEL0_100;
            default: return ODSEL0_10;
        endcase
    endfunction

    function automatic logic [6:0] odsel1_of(input logic [1:0] s);
        case (s)
            2'b10:   return ODSEL1_1000;
            2'b01:   return ODSEL1_100;
            default: return ODSEL1_10;
        endcase
    endfunction

    // A live request is newer than a pending one, so it takes precedence.
    always_comb begin
        req_vld_c    = req && (speed_sel != 2'b11);
        eff_speed_c  = req_vld_c ? speed_sel : pend_speed;
        chg_c        = (req_vld_c || pend_vld) && (eff_speed_c != speed_cur);
        odsel0_nxt_c = odsel0_of(eff_speed_c);
        odsel1_nxt_c = odsel1_of(eff_speed_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_PLL_RST;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            rst_cnt       <= '0;
            settle_cnt    <= '0;
            tmo_cnt       <= '0;
            retry_cnt     <= '0;
            pend_vld      <= 1'b0;
            pend_speed    <= 2'b10;
            pll_reset     <= 1'b1;
            odsel0        <= ODSEL0_1000;
            odsel1        <= ODSEL1_1000;
            speed_cur     <= 2'b10;
            ready         <= 1'b0;
            busy          <= 1'b1;
            err           <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            case (state)
                S_PLL_RST: begin
                    if (req_vld_c) begin
                        pend_vld   <= 1'b1;
                        pend_speed <= speed_sel;
                    end
                    if (rst_cnt == RW'(RST_CYC - 1)) begin
                        rst_cnt    <= '0;
                        settle_cnt <= '0;
                        tmo_cnt    <= '0;
                        pll_reset  <= 1'b0;
                        state      <= S_WAIT_LOCK;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (req_vld_c) begin
                        pend_vld   <= 1'b1;
                        pend_speed <= speed_sel;
                    end
                    tmo_cnt    <= tmo_cnt + TW'(1);
                    settle_cnt <= lock_s ? settle_cnt + SW'(1) : '0;
                    // Successful settling wins over a timeout on the same cycle.
                    if (lock_s && (settle_cnt == SW'(SETTLE_CYC - 1))) begin
                        retry_cnt <= '0;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_LOCKED;
                    end else if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                        retry_cnt <= retry_cnt + YW'(1);
                        if (retry_cnt == YW'(MAX_RETRY - 1)) begin
                            busy  <= 1'b0;
                            err   <= 1'b1;
                            state <= S_ERROR;
                        end else begin
                            pll_reset <= 1'b1;
                            state     <= S_PLL_RST;
                        end
                    end
                end
                S_LOCKED: begin
                    pend_vld <= 1'b0;
                    if (chg_c || !lock_s) begin
                        pll_reset <= 1'b1;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        rst_cnt   <= '0;
                        state     <= S_PLL_RST;
                    end
                    if (chg_c) begin
                        speed_cur <= eff_speed_c;
                        odsel0    <= odsel0_nxt_c;
                        odsel1    <= odsel1_nxt_c;
                    end
                    if (!lock_s && (lock_loss_cnt != 8'hFF)) begin
                        lock_loss_cnt <= lock_loss_cnt + 8'd1;
                    end
                end
                S_ERROR: begin
                    // Any valid request restarts the whole sequence from scratch.
                    if (req_vld_c) begin
                        err       <= 1'b0;
                        retry_cnt <= '0;
                        pend_vld  <= 1'b0;
                        speed_cur <= eff_speed_c;
                        odsel0    <= odsel0_nxt_c;
                        odsel1    <= odsel1_nxt_c;
                        pll_reset <= 1'b1;
                        busy      <= 1'b1;
                        rst_cnt   <= '0;
                        state     <= S_PLL_RST;
                    end
                end
                default: state <= S_PLL_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_pll_ctrl.sv
// Directed bench for gmii_pll_ctrl with short sequencing parameters.
module tb_gmii_pll_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] speed_sel;
    logic       req;
    logic       pll_lock;
    logic       pll_reset;
    logic [6:0] odsel0;
    logic [6:0] odsel1;
    logic [1:0] speed_cur;
    logic       ready;
    logic       busy;
    logic       err;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_loss = 0;

    gmii_pll_ctrl #(
        .RST_CYC(4), .SETTLE_CYC(8), .LOCK_TIMEOUT(32), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .speed_sel(speed_sel), .req(req),
        .pll_lock(pll_lock), .pll_reset(pll_reset), .odsel0(odsel0),
        .odsel1(odsel1), .speed_cur(speed_cur), .ready(ready), .busy(busy),
        .err(err), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until ready is observed high.
    task automatic wait_ready(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // One-cycle pll_lock dropout; returns once the FSM has reacted.
    task automatic pulse_lock();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_lock = 1'b1; req = 1'b0; speed_sel = 2'b10;
        repeat (3) step();
        n_checks++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL reset.pll_reset got %b exp 1", pll_reset); end
        n_checks++; if (busy !== 1'b1 || ready !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset.flags got busy=%b ready=%b err=%b exp 1/0/0", busy, ready, err); end
        n_checks++; if (odsel0 !== 7'd8 || odsel1 !== 7'd40) begin n_fail++; $display("FAIL reset.odsel got %0d/%0d exp 8/40", odsel0, odsel1); end
        n_checks++; if (speed_cur !== 2'b10 || lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset.speed_cnt got %b/%0d exp 10/0", speed_cur, lock_loss_cnt); end
    endtask

    task automatic test_power_up();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++; if (pll_reset !== (i < 4)) begin n_fail++; $display("FAIL powerup.pll_reset cyc %0d got %b exp %b", i, pll_reset, (i < 4)); end
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            n_checks++; if (ready !== (i == 8)) begin n_fail++; $display("FAIL powerup.ready cyc %0d got %b exp %b", i, ready, (i == 8)); end
        end
        n_checks++; if (busy !== 1'b0 || odsel0 !== 7'd8 || speed_cur !== 2'b10) begin n_fail++; $display("FAIL powerup.final got busy=%b odsel0=%0d speed=%b exp 0/8/10", busy, odsel0, speed_cur); end
    endtask

    task automatic test_speed_change();
        speed_sel = 2'b01; req = 1'b1;
        step();
        req = 1'b0;
        n_checks++; if (ready !== 1'b0 || pll_reset !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL speed.enter got ready=%b pll_reset=%b busy=%b exp 0/1/1", ready, pll_reset, busy); end
        n_checks++; if (odsel0 !== 7'd40 || odsel1 !== 7'd40 || speed_cur !== 2'b01) begin n_fail++; $display("FAIL speed.apply got %0d/%0d/%b exp 40/40/01", odsel0, odsel1, speed_cur); end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++; if (pll_reset !== (i < 4)) begin n_fail++; $display("FAIL speed.pll_reset cyc %0d got %b exp %b", i, pll_reset, (i < 4)); end
        end
        for (int i = 1; i <= 8; i++) step();
        n_checks++; if (ready !== 1'b1 || speed_cur !== 2'b01) begin n_fail++; $display("FAIL speed.relock got ready=%b speed=%b exp 1/01", ready, speed_cur); end
    endtask

    task automatic test_lock_loss();
        bit ok;
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss.sync_delay got ready=%b exp 1", ready); end
        step();
        exp_loss = 1;
        n_checks++; if (ready !== 1'b0 || pll_reset !== 1'b1) begin n_fail++; $display("FAIL loss.enter got ready=%b pll_reset=%b exp 0/1", ready, pll_reset); end
        n_checks++; if (lock_loss_cnt !== 8'(exp_loss) || speed_cur !== 2'b01 || odsel0 !== 7'd40) begin n_fail++; $display("FAIL loss.state got cnt=%0d speed=%b odsel0=%0d exp %0d/01/40", lock_loss_cnt, speed_cur, odsel0, exp_loss); end
        wait_ready(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL loss.relock got timeout exp ready"); end
    endtask

    task automatic test_simultaneous();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        speed_sel = 2'b10; req = 1'b1;
        step();
        req = 1'b0;
        exp_loss++;
        n_checks++; if (pll_reset !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL simul.enter got pll_reset=%b ready=%b exp 1/0", pll_reset, ready); end
        n_checks++; if (speed_cur !== 2'b10 || odsel0 !== 7'd8 || lock_loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL simul.apply got speed=%b odsel0=%0d cnt=%0d exp 10/8/%0d", speed_cur, odsel0, lock_loss_cnt, exp_loss); end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++; if (pll_reset !== (i < 4)) begin n_fail++; $display("FAIL simul.pll_reset cyc %0d got %b exp %b", i, pll_reset, (i < 4)); end
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            n_checks++; if (pll_reset !== 1'b0 || ready !== (i == 8)) begin n_fail++; $display("FAIL simul.single_rst cyc %0d got pll_reset=%b ready=%b exp 0/%b", i, pll_reset, ready, (i == 8)); end
        end
    endtask

    task automatic test_ignored_req();
        speed_sel = 2'b11; req = 1'b1;
        step();
        req = 1'b0;
        n_checks++; if (ready !== 1'b1 || pll_reset !== 1'b0 || speed_cur !== 2'b10) begin n_fail++; $display("FAIL ignore.invalid got ready=%b pll_reset=%b speed=%b exp 1/0/10", ready, pll_reset, speed_cur); end
        speed_sel = 2'b10; req = 1'b1;
        step();
        req = 1'b0;
        n_checks++; if (ready !== 1'b1 || pll_reset !== 1'b0 || odsel0 !== 7'd8) begin n_fail++; $display("FAIL ignore.same got ready=%b pll_reset=%b odsel0=%0d exp 1/0/8", ready, pll_reset, odsel0); end
        repeat (3) step();
        n_checks++; if (ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ignore.stable got ready=%b busy=%b exp 1/0", ready, busy); end
    endtask

    task automatic test_retry_exhaust();
        int n;
        int rises;
        logic prev;
        bit ok;
        pll_lock = 1'b0;
        repeat (3) step();
        exp_loss++;
        n_checks++; if (pll_reset !== 1'b1 || lock_loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL retry.enter got pll_reset=%b cnt=%0d exp 1/%0d", pll_reset, lock_loss_cnt, exp_loss); end
        repeat (4) step();
        n = 0; rises = 0; prev = pll_reset;
        while (err !== 1'b1 && n < 200) begin
            step();
            n++;
            if (pll_reset === 1'b1 && prev === 1'b0) rises++;
            prev = pll_reset;
        end
        n_checks++; if (n !== 68) begin n_fail++; $display("FAIL retry.cycles got %0d exp 68", n); end
        n_checks++; if (rises !== 1) begin n_fail++; $display("FAIL retry.attempts got %0d resets exp 1", rises); end
        n_checks++; if (err !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL retry.error got err=%b busy=%b ready=%b exp 1/0/0", err, busy, ready); end
        repeat (5) step();
        n_checks++; if (err !== 1'b1 || pll_reset !== 1'b0) begin n_fail++; $display("FAIL retry.stay got err=%b pll_reset=%b exp 1/0", err, pll_reset); end
        speed_sel = 2'b00; req = 1'b1;
        step();
        req = 1'b0;
        n_checks++; if (err !== 1'b0 || pll_reset !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL retry.recover got err=%b pll_reset=%b busy=%b exp 0/1/1", err, pll_reset, busy); end
        n_checks++; if (odsel0 !== 7'd100 || odsel1 !== 7'd40 || speed_cur !== 2'b00) begin n_fail++; $display("FAIL retry.apply got %0d/%0d/%b exp 100/40/00", odsel0, odsel1, speed_cur); end
        pll_lock = 1'b1;
        wait_ready(60, ok);
        n_checks++; if (!ok || speed_cur !== 2'b00) begin n_fail++; $display("FAIL retry.relock got ok=%b speed=%b exp 1/00", ok, speed_cur); end
    endtask

    task automatic test_pending();
        bit ok;
        speed_sel = 2'b10; req = 1'b1;
        step();
        req = 1'b0;
        wait_ready(40, ok);
        n_checks++; if (!ok || speed_cur !== 2'b10 || odsel0 !== 7'd8) begin n_fail++; $display("FAIL pend.setup got ok=%b speed=%b odsel0=%0d exp 1/10/8", ok, speed_cur, odsel0); end
        pll_lock = 1'b0;
        repeat (3) step();
        exp_loss++;
        repeat (4) step();
        speed_sel = 2'b01; req = 1'b1;
        step();
        speed_sel = 2'b00;
        step();
        req = 1'b0;
        n_checks++; if (speed_cur !== 2'b10 || busy !== 1'b1 || pll_reset !== 1'b0) begin n_fail++; $display("FAIL pend.held got speed=%b busy=%b pll_reset=%b exp 10/1/0", speed_cur, busy, pll_reset); end
        pll_lock = 1'b1;
        wait_ready(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pend.lock got timeout exp ready"); end
        step();
        n_checks++; if (ready !== 1'b0 || pll_reset !== 1'b1) begin n_fail++; $display("FAIL pend.apply got ready=%b pll_reset=%b exp 0/1", ready, pll_reset); end
        n_checks++; if (speed_cur !== 2'b00 || odsel0 !== 7'd100) begin n_fail++; $display("FAIL pend.speed got speed=%b odsel0=%0d exp 00/100", speed_cur, odsel0); end
        wait_ready(40, ok);
        n_checks++; if (!ok || speed_cur !== 2'b00 || lock_loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL pend.final got ok=%b speed=%b cnt=%0d exp 1/00/%0d", ok, speed_cur, lock_loss_cnt, exp_loss); end
    endtask

    task automatic test_loss_saturation();
        bit ok;
        ok = 1'b1;
        while (exp_loss < 255 && ok) begin
            pulse_lock();
            exp_loss++;
            wait_ready(40, ok);
        end
        n_checks++; if (!ok || lock_loss_cnt !== 8'd255) begin n_fail++; $display("FAIL sat.reach got ok=%b cnt=%0d exp 1/255", ok, lock_loss_cnt); end
        pulse_lock();
        n_checks++; if (pll_reset !== 1'b1 || lock_loss_cnt !== 8'd255) begin n_fail++; $display("FAIL sat.hold got pll_reset=%b cnt=%0d exp 1/255", pll_reset, lock_loss_cnt); end
        wait_ready(40, ok);
        n_checks++; if (!ok || speed_cur !== 2'b00 || lock_loss_cnt !== 8'd255) begin n_fail++; $display("FAIL sat.final got ok=%b speed=%b cnt=%0d exp 1/00/255", ok, speed_cur, lock_loss_cnt); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_speed_change();
        test_lock_loss();
        test_simultaneous();
        test_ignored_req();
        test_retry_exhaust();
        test_pending();
        test_loss_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_pll_ctrl.md
GMII_PLL_CTRL -- requirements
Module: gmii_pll_ctrl

Interface
REQ-001 SHALL have parameter RST_CYC, default 16: cycles pll_reset is held high per attempt.
REQ-002 SHALL have parameter SETTLE_CYC, default 1024: consecutive synchronised-lock cycles needed before ready.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65536: WAIT_LOCK cycles allowed per attempt.
REQ-004 SHALL have parameter MAX_RETRY, default 4: failed attempts allowed before ERROR.
REQ-005 SHALL have parameters ODSEL0_1000, ODSEL0_100 and ODSEL0_10, defaults 8, 40, 100: 7-bit channel-0 divider codes per speed.
REQ-006 SHALL have parameters ODSEL1_1000, ODSEL1_100 and ODSEL1_10, defaults 40, 40, 40: 7-bit channel-1 divider codes per speed.
REQ-007 SHALL have port clk, input, 1: free-running reference clock; the single clock of the block.
REQ-008 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port speed_sel, input, 2: requested speed; 2'b10 = 1000M, 2'b01 = 100M, 2'b00 = 10M, 2'b11 = invalid.
REQ-010 SHALL have port req, input, 1: one-cycle request to apply speed_sel.
REQ-011 SHALL have port pll_lock, input, 1: asynchronous PLL lock indication.
REQ-012 SHALL have port pll_reset, output, 1: active-high PLL reset.
REQ-013 SHALL have ports odsel0 and odsel1, output, 7 each: dynamic divider codes to the PLL.
REQ-014 SHALL have port speed_cur, output, 2: currently applied speed.
REQ-015 SHALL have ports ready, busy and err, output, 1 each: locked and stable / sequencing / retries exhausted.
REQ-016 SHALL have port lock_loss_cnt, output, 8: saturating count of lock losses while in LOCKED.

Function
REQ-017 SHALL synchronise pll_lock through two flops (lock_s); all lock decisions use lock_s.
REQ-018 SHALL implement states PLL_RST, WAIT_LOCK, LOCKED and ERROR, one-hot or binary.
REQ-019 SHALL, in PLL_RST, drive pll_reset=1 for exactly RST_CYC cycles, then enter WAIT_LOCK with pll_reset=0.
REQ-020 SHALL, in WAIT_LOCK, count consecutive lock_s=1 cycles (restarting at 0 on any lock_s=0) and enter LOCKED when the count reaches SETTLE_CYC.
REQ-021 SHALL, in WAIT_LOCK, time the attempt from entry; on reaching LOCK_TIMEOUT it increments retry_cnt and goes to PLL_RST, or to ERROR if retry_cnt+1 equals MAX_RETRY.
REQ-022 SHALL clear retry_cnt on entry to LOCKED.
REQ-023 SHALL, in LOCKED, drive ready=1 and busy=0; in PLL_RST/WAIT_LOCK drive busy=1 and ready=0; in ERROR drive err=1 and busy=ready=0.
REQ-024 SHALL, in LOCKED, on req with valid speed_sel different from speed_cur, register speed_cur and odsel0/odsel1 from the parameter table and enter PLL_RST next cycle; ready falls on that same cycle.
REQ-025 SHALL ignore req in LOCKED when speed_sel equals speed_cur or is 2'b11.
REQ-026 SHALL, in LOCKED, on lock_s=0, increment lock_loss_cnt (saturating at 255) and enter PLL_RST with unchanged speed.
REQ-027 SHALL give a simultaneous valid speed-change req and lock loss in LOCKED the following outcome: a single PLL_RST entry, the new speed applied, and lock_loss_cnt incremented.
REQ-028 SHALL latch a valid req arriving in PLL_RST or WAIT_LOCK into a one-deep pending register, last request wins.
REQ-029 SHALL apply a pending request on the first LOCKED cycle, using the REQ-024 rules, and clear it.
REQ-030 SHALL, in ERROR, on any valid req, clear err and retry_cnt, apply speed_sel, and enter PLL_RST.
REQ-031 SHALL change odsel0/odsel1 only while in PLL_RST entry or PLL_RST, never while pll_reset=0.

Reset
REQ-032 SHALL, asynchronously on rst_n=0, force state=PLL_RST, pll_reset=1, speed_cur=2'b10, odsel0=ODSEL0_1000, odsel1=ODSEL1_1000, ready=0, busy=1, err=0, lock_loss_cnt=0, retry_cnt=0, pending cleared, all counters 0.
REQ-033 SHALL, after rst_n release, run a full PLL_RST sequence; an rst_n assertion mid-sequence restarts it from REQ-032 values.

Verification (bench parameters: RST_CYC=4, SETTLE_CYC=8, LOCK_TIMEOUT=32, MAX_RETRY=2)
REQ-034 SHALL verify power-up: release rst_n, pll_lock=1 from cycle 0 -> pll_reset high 4 cycles; ready=1 after 8 stable lock_s cycles; odsel0=8, speed_cur=2'b10.
REQ-035 SHALL verify a speed change: in LOCKED, req with speed_sel=2'b01 -> next cycle ready=0, odsel0=40, pll_reset=1 for 4 cycles, relock -> ready=1, speed_cur=2'b01.
REQ-036 SHALL verify retry exhaustion: pll_lock held 0 -> two 32-cycle timeouts -> err=1, busy=0; then req with 2'b00 -> err=0, odsel0=100, pll_reset=1.
REQ-037 SHALL verify lock loss: in LOCKED, pll_lock low 1 cycle -> lock_loss_cnt 0->1, PLL_RST entered, speed unchanged; 256 losses -> lock_loss_cnt stays 255.
REQ-038 SHALL verify pending and ignored requests: req 2'b01 then req 2'b00 during WAIT_LOCK -> after lock, speed_cur=2'b00; req 2'b11 in LOCKED -> no state change.
